// File: rtl/open_list_pq.sv
// open_list_pq: a bank of independent sorted priority channels for an A* open list.
//
// Each channel holds up to QUEUE_SIZE {key, data} entries kept in ascending key order, with
// slot 0 as the head. Equal keys keep their insertion order. A channel accepts one insert and
// one pop per cycle, and both may fire in the same cycle. The gmin_* outputs name the channel
// whose head has the smallest key.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush[i]              synchronous clear of channel i; wins over insert and pop
//   ins_valid/ins_ready   per-channel insert handshake; ins_key / ins_data carry the entry
//   out_valid/out_ready   per-channel head handshake; out_key / out_data come from slot 0
//   count                 per-channel occupancy, $clog2(QUEUE_SIZE+1) bits per channel
//   drop                  one-cycle pulse, registered, when an entry is discarded (EVICT_MODE=1)
//   gmin_valid/chan/key   smallest valid head; ties resolve to the lowest channel index
module open_list_pq #(
  parameter int unsigned NUM_QUEUES = 8,
  parameter int unsigned QUEUE_SIZE = 16,
  parameter int unsigned KEY_W      = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned EVICT_MODE = 0
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_QUEUES-1:0]                        flush,
  input  logic [NUM_QUEUES-1:0]                        ins_valid,
  output logic [NUM_QUEUES-1:0]                        ins_ready,
  input  logic [NUM_QUEUES*KEY_W-1:0]                  ins_key,
  input  logic [NUM_QUEUES*DATA_W-1:0]                 ins_data,
  output logic [NUM_QUEUES-1:0]                        out_valid,
  input  logic [NUM_QUEUES-1:0]                        out_ready,
  output logic [NUM_QUEUES*KEY_W-1:0]                  out_key,
  output logic [NUM_QUEUES*DATA_W-1:0]                 out_data,
  output logic [NUM_QUEUES*$clog2(QUEUE_SIZE+1)-1:0]   count,
  output logic [NUM_QUEUES-1:0]                        drop,
  output logic                                         gmin_valid,
  output logic [$clog2(NUM_QUEUES)-1:0]                gmin_chan,
  output logic [KEY_W-1:0]                             gmin_key
);

  localparam int unsigned CW  = $clog2(QUEUE_SIZE + 1);
  localparam int unsigned CHW = $clog2(NUM_QUEUES);
  localparam int          QS  = int'(QUEUE_SIZE);
  localparam int          NQ  = int'(NUM_QUEUES);
  localparam logic [CW-1:0] QS_C = CW'(QUEUE_SIZE);

  // Head keys gated by occupancy so stale slot contents never reach the outputs.
  logic [NUM_QUEUES-1:0][KEY_W-1:0] head_key;

  for (genvar g = 0; g < NQ; g++) begin : g_chan
    logic [KEY_W-1:0]  key_q     [QUEUE_SIZE];
    logic [KEY_W-1:0]  key_d     [QUEUE_SIZE];
    logic [DATA_W-1:0] data_q    [QUEUE_SIZE];
    logic [DATA_W-1:0] data_d    [QUEUE_SIZE];
    logic [KEY_W-1:0]  base_key  [QUEUE_SIZE];
    logic [DATA_W-1:0] base_data [QUEUE_SIZE];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     base_cnt;
    logic [CW-1:0]     pos;
    logic              drop_q, drop_d;
    logic              nonempty, pop, fire;
    logic [KEY_W-1:0]  new_key;
    logic [DATA_W-1:0] new_data;

    assign new_key  = ins_key[g*KEY_W +: KEY_W];
    assign new_data = ins_data[g*DATA_W +: DATA_W];
    assign nonempty = (cnt_q != '0);
    assign pop      = nonempty & out_ready[g] & ~flush[g];

    // rst_n gates ready so nothing is accepted while the channel is held in reset.
    if (EVICT_MODE == 0) begin : g_reject
      assign ins_ready[g] = rst_n & ~flush[g] & ((cnt_q < QS_C) | pop);
    end else begin : g_evict
      assign ins_ready[g] = rst_n & ~flush[g];
    end

    assign fire = ins_valid[g] & ins_ready[g];

    // Base view: the array as it stands after this cycle's pop, before any insert.
    always_comb begin
      base_cnt = cnt_q;
      for (int s = 0; s < QS; s++) begin
        base_key[s]  = key_q[s];
        base_data[s] = data_q[s];
      end
      if (pop) begin
        base_cnt = cnt_q - CW'(1);
        for (int s = 0; s < QS - 1; s++) begin
          base_key[s]  = key_q[s + 1];
          base_data[s] = data_q[s + 1];
        end
      end
    end

    // Insert position = number of valid entries whose key is <= the new key. Since the array
    // is sorted, this lands the new entry after every equal key (stable order).
    always_comb begin
      pos = '0;
      for (int s = 0; s < QS; s++) begin
        if ((CW'(s) < base_cnt) && (base_key[s] <= new_key)) begin
          pos = pos + CW'(1);
        end
      end
    end

    always_comb begin
      key_d  = base_key;
      data_d = base_data;
      cnt_d  = base_cnt;
      drop_d = 1'b0;
      if (fire) begin
        if ((base_cnt == QS_C) && (pos == QS_C)) begin
          // Full and the new key is not below the tail: the new entry is the one discarded.
          drop_d = 1'b1;
        end else begin
          if (pos == '0) begin
            key_d[0]  = new_key;
            data_d[0] = new_data;
          end
          for (int s = 1; s < QS; s++) begin
            if (CW'(s) == pos) begin
              key_d[s]  = new_key;
              data_d[s] = new_data;
            end else if (CW'(s) > pos) begin
              key_d[s]  = base_key[s - 1];
              data_d[s] = base_data[s - 1];
            end
          end
          // Full base can only be reached with eviction enabled; the shift pushed the tail out.
          if (base_cnt == QS_C) begin
            drop_d = 1'b1;
          end else begin
            cnt_d = base_cnt + CW'(1);
          end
        end
      end
      if (flush[g]) begin
        cnt_d  = '0;
        drop_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        drop_q <= 1'b0;
        for (int s = 0; s < QS; s++) begin
          key_q[s]  <= '0;
          data_q[s] <= '0;
        end
      end else begin
        cnt_q  <= cnt_d;
        drop_q <= drop_d;
        key_q  <= key_d;
        data_q <= data_d;
      end
    end

    assign out_valid[g]                  = nonempty;
    assign head_key[g]                   = nonempty ? key_q[0] : '0;
    assign out_key[g*KEY_W +: KEY_W]     = head_key[g];
    assign out_data[g*DATA_W +: DATA_W]  = nonempty ? data_q[0] : '0;
    assign count[g*CW +: CW]             = cnt_q;
    assign drop[g]                       = drop_q;
  end

  // Global minimum over valid heads; strict < keeps the lowest index on ties.
  always_comb begin
    gmin_valid = 1'b0;
    gmin_chan  = '0;
    gmin_key   = '0;
    for (int c = 0; c < NQ; c++) begin
      if (out_valid[c] && (!gmin_valid || (head_key[c] < gmin_key))) begin
        gmin_valid = 1'b1;
        gmin_chan  = CHW'(c);
        gmin_key   = head_key[c];
      end
    end
  end

endmodule

// File: tb/tb_open_list_pq.sv
// Self-checking bench for open_list_pq. Two instances (reject and evict modes) share the same
// stimulus; a queue-based model of each sorted channel predicts every output.
module tb_open_list_pq;
  localparam int NQ = 8;
  localparam int QS = 16;
  localparam int KW = 16;
  localparam int DW = 32;
  localparam int CW = 5;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NQ-1:0]     flush, ins_valid, out_ready;
  logic [NQ*KW-1:0]  ins_key;
  logic [NQ*DW-1:0]  ins_data;

  logic [NQ-1:0]     rdy_w   [2];
  logic [NQ-1:0]     ov_w    [2];
  logic [NQ-1:0]     drop_w  [2];
  logic [NQ*KW-1:0]  okey_w  [2];
  logic [NQ*DW-1:0]  odata_w [2];
  logic [NQ*CW-1:0]  cnt_w   [2];
  logic              gv_w    [2];
  logic [2:0]        gc_w    [2];
  logic [KW-1:0]     gk_w    [2];

  int tests = 0;
  int fails = 0;

  // Model: mq[m*NQ+c] is channel c of instance m, head at index 0.
  ent_t          mq [2*NQ][$];
  logic [NQ-1:0] mdrop [2];

  always #5 clk = ~clk;

  open_list_pq #(.EVICT_MODE(0)) u_rej (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ins_valid(ins_valid), .ins_ready(rdy_w[0]),
    .ins_key(ins_key), .ins_data(ins_data), .out_valid(ov_w[0]), .out_ready(out_ready),
    .out_key(okey_w[0]), .out_data(odata_w[0]), .count(cnt_w[0]), .drop(drop_w[0]),
    .gmin_valid(gv_w[0]), .gmin_chan(gc_w[0]), .gmin_key(gk_w[0])
  );

  open_list_pq #(.EVICT_MODE(1)) u_evt (
    .clk(clk), .rst_n(rst_n), .flush(flush), .ins_valid(ins_valid), .ins_ready(rdy_w[1]),
    .ins_key(ins_key), .ins_data(ins_data), .out_valid(ov_w[1]), .out_ready(out_ready),
    .out_key(okey_w[1]), .out_data(odata_w[1]), .count(cnt_w[1]), .drop(drop_w[1]),
    .gmin_valid(gv_w[1]), .gmin_chan(gc_w[1]), .gmin_key(gk_w[1])
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  function automatic bit exp_ready(int m, int c);
    int n;
    n = mq[m*NQ+c].size();
    if (!rst_n || flush[c]) return 1'b0;
    return (m == 1) || (n < QS) || ((n != 0) && out_ready[c]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2*NQ; i++) mq[i].delete();
    mdrop[0] = '0;
    mdrop[1] = '0;
  endtask

  task automatic model_insert(int idx, ent_t e);
    int p;
    p = mq[idx].size();
    for (int i = mq[idx].size() - 1; i >= 0; i--) begin
      if (mq[idx][i].k > e.k) p = i;
    end
    mq[idx].insert(p, e);
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NQ; c++) begin
        int   idx;
        bit   rdy, popf;
        ent_t e;
        idx  = m*NQ + c;
        rdy  = exp_ready(m, c);
        popf = (mq[idx].size() != 0) && out_ready[c] && !flush[c];
        mdrop[m][c] = 1'b0;
        if (flush[c]) begin
          mq[idx].delete();
        end else begin
          if (popf) void'(mq[idx].pop_front());
          if (ins_valid[c] && rdy) begin
            e.k = ins_key[c*KW +: KW];
            e.d = ins_data[c*DW +: DW];
            if (mq[idx].size() == QS) begin
              mdrop[m][c] = 1'b1;
              if (e.k < mq[idx][QS-1].k) begin
                void'(mq[idx].pop_back());
                model_insert(idx, e);
              end
            end else begin
              model_insert(idx, e);
            end
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush     = '0;
    ins_valid = '0;
    out_ready = '0;
  endtask

  task automatic clear_all();
    idle_inputs();
    flush = '1;
    tick();
    flush = '0;
  endtask

  task automatic set_ins(int c, logic [KW-1:0] k, logic [DW-1:0] d);
    ins_valid[c]       = 1'b1;
    ins_key[c*KW +: KW] = k;
    ins_data[c*DW +: DW] = d;
  endtask

  task automatic test_reset();
    #2;
    rst_n     = 1'b0;
    ins_valid = '1;
    out_ready = '1;
    ins_key   = {NQ{16'h1234}};
    #1;
    for (int m = 0; m < 2; m++) begin
      tests++; if (ov_w[m] !== '0) begin fails++; $display("FAIL reset_out_valid m=%0d got %0h exp 0", m, ov_w[m]); end
      tests++; if (cnt_w[m] !== '0) begin fails++; $display("FAIL reset_count m=%0d got %0h exp 0", m, cnt_w[m]); end
      tests++; if (drop_w[m] !== '0) begin fails++; $display("FAIL reset_drop m=%0d got %0h exp 0", m, drop_w[m]); end
      tests++; if (okey_w[m] !== '0) begin fails++; $display("FAIL reset_out_key m=%0d got %0h exp 0", m, okey_w[m]); end
      tests++; if (odata_w[m] !== '0) begin fails++; $display("FAIL reset_out_data m=%0d got %0h exp 0", m, odata_w[m]); end
      tests++; if (rdy_w[m] !== '0) begin fails++; $display("FAIL reset_ins_ready m=%0d got %0h exp 0", m, rdy_w[m]); end
      tests++; if ({gv_w[m], gc_w[m], gk_w[m]} !== '0) begin fails++; $display("FAIL reset_gmin m=%0d got %0b/%0d/%0h exp 0/0/0", m, gv_w[m], gc_w[m], gk_w[m]); end
    end
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ordering();
    logic [KW-1:0] ek [4];
    logic [DW-1:0] ed [4];
    ek = '{16'd3, 16'd3, 16'd7, 16'd9};
    ed = '{32'hB, 32'hD, 32'hA, 32'hC};
    clear_all();
    set_ins(0, 16'd7, 32'hA); tick();
    set_ins(0, 16'd3, 32'hB); tick();
    set_ins(0, 16'd9, 32'hC); tick();
    set_ins(0, 16'd3, 32'hD); tick();
    ins_valid = '0;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int m = 0; m < 2; m++) begin
        tests++;
        if (cnt_w[m][0 +: CW] !== CW'(4 - i)) begin
          fails++; $display("FAIL order_count m=%0d step=%0d got %0d exp %0d", m, i, cnt_w[m][0 +: CW], 4 - i);
        end
        if (i < 4) begin
          tests++;
          if ({okey_w[m][0 +: KW], odata_w[m][0 +: DW]} !== {ek[i], ed[i]}) begin
            fails++; $display("FAIL order_head m=%0d step=%0d got %0d/%0h exp %0d/%0h", m, i, okey_w[m][0 +: KW], odata_w[m][0 +: DW], ek[i], ed[i]);
          end
        end else begin
          tests++;
          if (ov_w[m][0] !== 1'b0) begin fails++; $display("FAIL order_empty m=%0d got %0b exp 0", m, ov_w[m][0]); end
        end
      end
      if (i < 4) tick();
    end
    out_ready = '0;
  endtask

  task automatic test_no_bypass();
    clear_all();
    set_ins(5, 16'd42, 32'h42);
    out_ready[5] = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      tests++; if (ov_w[m][5] !== 1'b0) begin fails++; $display("FAIL bypass_same_cycle m=%0d got %0b exp 0", m, ov_w[m][5]); end
    end
    tick();
    ins_valid = '0;
    for (int m = 0; m < 2; m++) begin
      tests++;
      if ({cnt_w[m][5*CW +: CW], okey_w[m][5*KW +: KW]} !== {5'd1, 16'd42}) begin
        fails++; $display("FAIL bypass_next m=%0d got %0d/%0d exp 1/42", m, cnt_w[m][5*CW +: CW], okey_w[m][5*KW +: KW]);
      end
    end
    tick();
    out_ready = '0;
    for (int m = 0; m < 2; m++) begin
      tests++; if (cnt_w[m][5*CW +: CW] !== 5'd0) begin fails++; $display("FAIL bypass_pop m=%0d got %0d exp 0", m, cnt_w[m][5*CW +: CW]); end
    end
  endtask

  task automatic test_full();
    clear_all();
    for (int i = 0; i < QS; i++) begin
      set_ins(2, KW'($urandom_range(1, 1000)), $urandom);
      tick();
    end
    ins_valid = '0;
    #1;
    tests++; if (rdy_w[0][2] !== 1'b0) begin fails++; $display("FAIL full_ready_rej got %0b exp 0", rdy_w[0][2]); end
    tests++; if (rdy_w[1][2] !== 1'b1) begin fails++; $display("FAIL full_ready_evt got %0b exp 1", rdy_w[1][2]); end
    set_ins(2, 16'd0, 32'hF00D);
    out_ready[2] = 1'b1;
    #1;
    tests++; if (rdy_w[0][2] !== 1'b1) begin fails++; $display("FAIL full_ready_pop got %0b exp 1", rdy_w[0][2]); end
    tick();
    idle_inputs();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if ({cnt_w[m][2*CW +: CW], okey_w[m][2*KW +: KW], odata_w[m][2*DW +: DW], drop_w[m][2]} !==
          {5'd16, 16'd0, 32'hF00D, 1'b0}) begin
        fails++; $display("FAIL full_swap m=%0d got cnt=%0d key=%0d data=%0h drop=%0b exp 16/0/f00d/0", m,
                          cnt_w[m][2*CW +: CW], okey_w[m][2*KW +: KW], odata_w[m][2*DW +: DW], drop_w[m][2]);
      end
    end
  endtask

  task automatic test_evict();
    logic [KW-1:0] ek;
    logic [DW-1:0] ed;
    clear_all();
    for (int i = 0; i < QS - 1; i++) begin
      set_ins(3, KW'($urandom_range(1, 49)), $urandom);
      tick();
    end
    set_ins(3, 16'd100, 32'h100);
    tick();
    set_ins(3, 16'd50, 32'h50);
    #1;
    tests++; if ({rdy_w[0][3], rdy_w[1][3]} !== 2'b01) begin fails++; $display("FAIL evict_ready got %0b%0b exp 01", rdy_w[0][3], rdy_w[1][3]); end
    tick();
    tests++; if (drop_w[1][3] !== 1'b1) begin fails++; $display("FAIL evict_drop_tail got %0b exp 1", drop_w[1][3]); end
    tests++; if (drop_w[0][3] !== 1'b0) begin fails++; $display("FAIL evict_drop_rej got %0b exp 0", drop_w[0][3]); end
    tests++; if (cnt_w[1][3*CW +: CW] !== 5'd16) begin fails++; $display("FAIL evict_count got %0d exp 16", cnt_w[1][3*CW +: CW]); end
    set_ins(3, 16'd200, 32'h200);
    tick();
    ins_valid = '0;
    tests++; if (drop_w[1][3] !== 1'b1) begin fails++; $display("FAIL evict_drop_new got %0b exp 1", drop_w[1][3]); end
    tests++; if (cnt_w[1][3*CW +: CW] !== 5'd16) begin fails++; $display("FAIL evict_count2 got %0d exp 16", cnt_w[1][3*CW +: CW]); end
    tick();
    tests++; if (drop_w[1][3] !== 1'b0) begin fails++; $display("FAIL evict_drop_pulse got %0b exp 0", drop_w[1][3]); end
    out_ready[3] = 1'b1;
    for (int i = 0; i < QS; i++) begin
      for (int m = 0; m < 2; m++) begin
        ek = mq[m*NQ+3][0].k;
        ed = mq[m*NQ+3][0].d;
        tests++;
        if ({okey_w[m][3*KW +: KW], odata_w[m][3*DW +: DW]} !== {ek, ed}) begin
          fails++; $display("FAIL evict_drain m=%0d i=%0d got %0d/%0h exp %0d/%0h", m, i, okey_w[m][3*KW +: KW], odata_w[m][3*DW +: DW], ek, ed);
        end
      end
      if (i == QS - 1) begin
        tests++;
        if (okey_w[1][3*KW +: KW] !== 16'd50) begin fails++; $display("FAIL evict_tail got %0d exp 50", okey_w[1][3*KW +: KW]); end
      end
      tick();
    end
    out_ready = '0;
  endtask

  task automatic test_gmin();
    clear_all();
    for (int m = 0; m < 2; m++) begin
      tests++; if ({gv_w[m], gc_w[m], gk_w[m]} !== '0) begin fails++; $display("FAIL gmin_empty m=%0d got %0b/%0d/%0d exp 0/0/0", m, gv_w[m], gc_w[m], gk_w[m]); end
    end
    set_ins(1, 16'd5, 32'h1);
    set_ins(3, 16'd5, 32'h3);
    set_ins(6, 16'd2, 32'h6);
    tick();
    ins_valid = '0;
    for (int m = 0; m < 2; m++) begin
      tests++; if ({gv_w[m], gc_w[m], gk_w[m]} !== {1'b1, 3'd6, 16'd2}) begin fails++; $display("FAIL gmin_first m=%0d got %0b/%0d/%0d exp 1/6/2", m, gv_w[m], gc_w[m], gk_w[m]); end
    end
    out_ready[6] = 1'b1;
    tick();
    out_ready = '0;
    for (int m = 0; m < 2; m++) begin
      tests++; if ({gv_w[m], gc_w[m], gk_w[m]} !== {1'b1, 3'd1, 16'd5}) begin fails++; $display("FAIL gmin_tie m=%0d got %0b/%0d/%0d exp 1/1/5", m, gv_w[m], gc_w[m], gk_w[m]); end
    end
  endtask

  task automatic test_flush();
    clear_all();
    for (int i = 0; i < 3; i++) begin
      set_ins(4, KW'(10 + i), 32'h40 + i);
      tick();
    end
    flush[4]     = 1'b1;
    out_ready[4] = 1'b1;
    set_ins(4, 16'd1, 32'h41);
    #1;
    for (int m = 0; m < 2; m++) begin
      tests++; if (rdy_w[m][4] !== 1'b0) begin fails++; $display("FAIL flush_ready m=%0d got %0b exp 0", m, rdy_w[m][4]); end
    end
    tick();
    idle_inputs();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if ({cnt_w[m][4*CW +: CW], ov_w[m][4], drop_w[m][4]} !== '0) begin
        fails++; $display("FAIL flush_clear m=%0d got cnt=%0d valid=%0b drop=%0b exp 0/0/0", m, cnt_w[m][4*CW +: CW], ov_w[m][4], drop_w[m][4]);
      end
    end
  endtask

  task automatic test_random();
    int pins, ppop;
    clear_all();
    for (int cyc = 0; cyc < 450; cyc++) begin
      pins = (cyc < 150) ? 90 : (cyc < 300) ? 50 : 20;
      ppop = (cyc < 150) ? 15 : (cyc < 300) ? 50 : 80;
      for (int c = 0; c < NQ; c++) begin
        flush[c]     = ($urandom_range(0, 99) < 1);
        ins_valid[c] = ($urandom_range(0, 99) < pins);
        out_ready[c] = ($urandom_range(0, 99) < ppop);
        ins_key[c*KW +: KW]  = ($urandom_range(0, 9) == 0) ? KW'($urandom) : KW'($urandom_range(0, 20));
        ins_data[c*DW +: DW] = $urandom;
      end
      #1;
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NQ; c++) begin
          tests++;
          if (rdy_w[m][c] !== exp_ready(m, c)) begin
            fails++; $display("FAIL rand_ready cyc=%0d m=%0d c=%0d got %0b exp %0b", cyc, m, c, rdy_w[m][c], exp_ready(m, c));
          end
        end
      end
      tick();
      for (int m = 0; m < 2; m++) begin
        bit            ev;
        int            ec;
        logic [KW-1:0] ekey;
        ev = 1'b0; ec = 0; ekey = '0;
        for (int c = 0; c < NQ; c++) begin
          int            n;
          logic [KW-1:0] hk;
          logic [DW-1:0] hd;
          n  = mq[m*NQ+c].size();
          hk = (n != 0) ? mq[m*NQ+c][0].k : '0;
          hd = (n != 0) ? mq[m*NQ+c][0].d : '0;
          tests++;
          if ({cnt_w[m][c*CW +: CW], ov_w[m][c], drop_w[m][c]} !== {CW'(n), (n != 0), mdrop[m][c]}) begin
            fails++; $display("FAIL rand_state cyc=%0d m=%0d c=%0d got cnt=%0d valid=%0b drop=%0b exp %0d/%0b/%0b",
                              cyc, m, c, cnt_w[m][c*CW +: CW], ov_w[m][c], drop_w[m][c], n, (n != 0), mdrop[m][c]);
          end
          tests++;
          if ({okey_w[m][c*KW +: KW], odata_w[m][c*DW +: DW]} !== {hk, hd}) begin
            fails++; $display("FAIL rand_head cyc=%0d m=%0d c=%0d got %0h/%0h exp %0h/%0h",
                              cyc, m, c, okey_w[m][c*KW +: KW], odata_w[m][c*DW +: DW], hk, hd);
          end
          if ((n != 0) && (!ev || (hk < ekey))) begin
            ev = 1'b1; ec = c; ekey = hk;
          end
        end
        tests++;
        if ({gv_w[m], gc_w[m], gk_w[m]} !== {ev, 3'(ec), ekey}) begin
          fails++; $display("FAIL rand_gmin cyc=%0d m=%0d got %0b/%0d/%0h exp %0b/%0d/%0h", cyc, m, gv_w[m], gc_w[m], gk_w[m], ev, ec, ekey);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < NQ; c++) set_ins(c, KW'($urandom_range(0, 30)), $urandom);
      tick();
    end
    out_ready = '1;
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      tests++;
      if ({ov_w[m], cnt_w[m], drop_w[m], rdy_w[m]} !== '0) begin
        fails++; $display("FAIL midreset_ctrl m=%0d got valid=%0h cnt=%0h drop=%0h ready=%0h exp 0", m, ov_w[m], cnt_w[m], drop_w[m], rdy_w[m]);
      end
      tests++;
      if ({okey_w[m], odata_w[m], gv_w[m], gc_w[m], gk_w[m]} !== '0) begin
        fails++; $display("FAIL midreset_data m=%0d got key=%0h data=%0h gmin=%0b/%0d/%0h exp 0", m, okey_w[m], odata_w[m], gv_w[m], gc_w[m], gk_w[m]);
      end
    end
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    set_ins(0, 16'd9, 32'h99);
    tick();
    idle_inputs();
    for (int m = 0; m < 2; m++) begin
      tests++;
      if ({cnt_w[m][0 +: CW], okey_w[m][0 +: KW], drop_w[m]} !== {5'd1, 16'd9, 8'h00}) begin
        fails++; $display("FAIL midreset_resume m=%0d got cnt=%0d key=%0d drop=%0h exp 1/9/0", m, cnt_w[m][0 +: CW], okey_w[m][0 +: KW], drop_w[m]);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    ins_key  = '0;
    ins_data = '0;
    idle_inputs();
    model_clear();
    test_reset();
    test_ordering();
    test_no_bypass();
    test_full();
    test_evict();
    test_gmin();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
